// File: rtl/fpu_drv_pkg.sv
// Shared types and constants for the FP unit request driver and its result classifier.
package fpu_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_START,
    ST_BUSY,
    ST_ACK,
    ST_ABORT
  } drv_state_e;

  localparam int NAN_B  = 2;
  localparam int INF_B  = 1;
  localparam int ZERO_B = 0;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'hFFC0_0000;

endpackage

// File: rtl/fpu_result_classify.sv
// Combinational {nan, inf, zero} decode of an IEEE-754 single; zero ignores the sign bit.
module fpu_result_classify
  import fpu_drv_pkg::*;
(
  input  logic [31:0] z_i,
  output logic [2:0]  flags_o
);

  logic [7:0]  exp_f;
  logic [22:0] frac_f;

  assign exp_f  = z_i[30:23];
  assign frac_f = z_i[22:0];

  always_comb begin
    flags_o         = '0;
    flags_o[NAN_B]  = (exp_f == EXP_MAX) && (frac_f != '0);
    flags_o[INF_B]  = (exp_f == EXP_MAX) && (frac_f == '0);
    flags_o[ZERO_B] = (exp_f == '0) && (frac_f == '0);
  end

endmodule

// File: rtl/fpu_request_driver.sv
// Drives one handshake-style FP unit: feeds operands, waits for the result, buffers it
// downstream, and resets the unit if it never answers.
//
// state      | meaning
// IDLE       | ready for a new operand pair
// WAIT_IDLE  | operands held, waiting for the unit to report idle
// START      | one-cycle start pulse
// BUSY       | waiting for output_valid, watchdog running
// ACK        | one-cycle ack pulse, count the operation
// ABORT      | watchdog expired, one-cycle unit reset, job dropped
module fpu_request_driver
  import fpu_drv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [31:0]      job_a_i,
  input  logic [31:0]      job_b_i,
  output logic [31:0]      fpu_a_o,
  output logic [31:0]      fpu_b_o,
  output logic             fpu_start_o,
  input  logic             fpu_idle_i,
  input  logic             fpu_valid_i,
  input  logic [31:0]      fpu_z_i,
  output logic             fpu_ack_o,
  output logic             fpu_rst_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_z_o,
  output logic [2:0]       res_flags_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] op_count_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  drv_state_e       state_q;
  logic             job_ready_q, fpu_start_q, fpu_ack_q, fpu_rst_q;
  logic             res_valid_q, err_q;
  logic [31:0]      fpu_a_q, fpu_b_q, res_z_q;
  logic [2:0]       res_flags_q;
  logic [CNT_W-1:0] op_count_q;
  logic [WD_W-1:0]  wd_q;

  logic             drain, slot_free;
  logic [2:0]       flags_d;
  logic [WD_W-1:0]  wd_d;

  fpu_result_classify u_classify (
    .z_i     (fpu_z_i),
    .flags_o (flags_d)
  );

  // A full result register still accepts a new capture when it drains in the same cycle.
  assign drain     = res_valid_q && res_ready_i;
  assign slot_free = !res_valid_q || res_ready_i;
  assign wd_d      = wd_q + WD_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      job_ready_q <= 1'b0;
      fpu_start_q <= 1'b0;
      fpu_ack_q   <= 1'b0;
      fpu_rst_q   <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      res_z_q     <= '0;
      res_flags_q <= '0;
      op_count_q  <= '0;
      wd_q        <= '0;
    end else begin
      fpu_start_q <= 1'b0;
      fpu_ack_q   <= 1'b0;
      fpu_rst_q   <= 1'b0;
      if (drain) res_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (job_valid_i && job_ready_q) begin
            fpu_a_q     <= job_a_i;
            fpu_b_q     <= job_b_i;
            job_ready_q <= 1'b0;
            state_q     <= ST_WAIT_IDLE;
          end else begin
            job_ready_q <= 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (fpu_idle_i) begin
            fpu_start_q <= 1'b1;
            wd_q        <= '0;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          wd_q    <= wd_d;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (fpu_valid_i) begin
            // With no room for the result the unit is left waiting and the watchdog holds.
            if (slot_free) begin
              res_z_q     <= fpu_z_i;
              res_flags_q <= flags_d;
              res_valid_q <= 1'b1;
              fpu_ack_q   <= 1'b1;
              state_q     <= ST_ACK;
            end
          end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            fpu_rst_q <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= ST_ABORT;
          end else begin
            wd_q <= wd_d;
          end
        end
        ST_ACK: begin
          op_count_q  <= op_count_q + CNT_W'(1);
          job_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_ABORT: begin
          job_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign job_ready_o   = job_ready_q;
  assign fpu_a_o       = fpu_a_q;
  assign fpu_b_o       = fpu_b_q;
  assign fpu_start_o   = fpu_start_q;
  assign fpu_ack_o     = fpu_ack_q;
  assign fpu_rst_o     = fpu_rst_q;
  assign res_valid_o   = res_valid_q;
  assign res_z_o       = res_z_q;
  assign res_flags_o   = res_flags_q;
  assign err_timeout_o = err_q;
  assign op_count_o    = op_count_q;

endmodule
